// File: rtl/cp0_int_ctrl_if.sv
// cp0_int_ctrl_if: IRQ, CPU handshake and config bus of the CP0 interrupt controller
// Signals: irq_in (raw requests), cpu_int/int_ack/eret (CPU handshake), pc_in/epc_out,
//   vector_out/cause_id (serviced channel), cfg_we/cfg_addr/cfg_wdata/cfg_rdata (register port).
// master drives requests and CPU/config inputs; slave is the controller.
interface cp0_int_ctrl_if #(parameter int NUM_IRQ = 8);
  logic [NUM_IRQ-1:0] irq_in;
  logic               cpu_int;
  logic               int_ack;
  logic               eret;
  logic [31:0]        pc_in;
  logic [31:0]        epc_out;
  logic [31:0]        vector_out;
  logic [4:0]         cause_id;
  logic               cfg_we;
  logic [1:0]         cfg_addr;
  logic [31:0]        cfg_wdata;
  logic [31:0]        cfg_rdata;
  modport master (
    output irq_in, int_ack, eret, pc_in, cfg_we, cfg_addr, cfg_wdata,
    input  cpu_int, epc_out, vector_out, cause_id, cfg_rdata
  );
  modport slave (
    input  irq_in, int_ack, eret, pc_in, cfg_we, cfg_addr, cfg_wdata,
    output cpu_int, epc_out, vector_out, cause_id, cfg_rdata
  );
endinterface

// File: rtl/cp0_int_ctrl.sv
// cp0_int_ctrl: prioritised multi-channel interrupt controller driving the CPU INT line
// Ports: clk, reset (sync, active-high), bus (cp0_int_ctrl_if.slave: IRQ lines, CPU
//   int/ack/eret handshake, EPC save, per-channel vector, STATUS/MASK/PENDING/EPC registers).
module cp0_int_ctrl #(
  parameter int          NUM_IRQ       = 8,
  parameter logic [31:0] EDGE_MASK     = 32'h0000_00FF,
  parameter logic [31:0] VECTOR_BASE   = 32'h0000_0004,
  parameter logic [31:0] VECTOR_STRIDE = 32'd4
) (
  input logic         clk,
  input logic         reset,
  cp0_int_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  localparam logic [NUM_IRQ-1:0] EDGE = EDGE_MASK[NUM_IRQ-1:0];
  state_t             r_state;
  logic [NUM_IRQ-1:0] r_irq_q;
  logic [NUM_IRQ-1:0] r_pend;
  logic [NUM_IRQ-1:0] r_mask;
  logic               r_ie;
  logic               r_cpu_int;
  logic [31:0]        r_epc;
  logic [4:0]         r_cause;
  logic [NUM_IRQ-1:0] w_pend;
  logic [NUM_IRQ-1:0] w_active;
  logic [NUM_IRQ-1:0] w_clr;
  logic [4:0]         w_sel;
  logic               w_ack;
  logic               w_eret;
  logic               w_wr_status;
  logic               w_wr_mask;
  logic               w_wr_pend;
  logic               w_wr_epc;
  logic               w_unused;
  // Level channels follow the registered line directly; only edge channels hold state.
  assign w_pend      = (r_pend & EDGE) | (r_irq_q & ~EDGE);
  assign w_active    = w_pend & r_mask;
  assign w_ack       = (r_state == REQ) && bus.int_ack;
  assign w_eret      = (r_state == SERVICE) && bus.eret;
  assign w_wr_status = bus.cfg_we && bus.cfg_addr == 2'd0;
  assign w_wr_mask   = bus.cfg_we && bus.cfg_addr == 2'd1;
  assign w_wr_pend   = bus.cfg_we && bus.cfg_addr == 2'd2;
  assign w_wr_epc    = bus.cfg_we && bus.cfg_addr == 2'd3;
  assign w_clr       = (w_wr_pend ? bus.cfg_wdata[NUM_IRQ-1:0] : '0) |
                       (w_ack ? NUM_IRQ'(1) << r_cause : '0);
  assign w_unused    = &{1'b0, bus.cfg_wdata};
  always_comb begin
    w_sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) if (w_active[i]) w_sel = 5'(i);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_irq_q   <= '0;
      r_pend    <= '0;
      r_mask    <= '0;
      r_ie      <= 1'b0;
      r_cpu_int <= 1'b0;
      r_epc     <= '0;
      r_cause   <= '0;
    end else begin
      r_irq_q <= bus.irq_in;
      // OR-ing the rising edge after the clear lets a new edge beat a same-cycle clear.
      r_pend  <= ((r_pend & ~w_clr) | (bus.irq_in & ~r_irq_q)) & EDGE;
      if (w_wr_mask) r_mask <= bus.cfg_wdata[NUM_IRQ-1:0];
      r_ie    <= w_ack ? 1'b0 : w_eret ? 1'b1 : w_wr_status ? bus.cfg_wdata[0] : r_ie;
      r_epc   <= w_ack ? bus.pc_in : w_wr_epc ? bus.cfg_wdata : r_epc;
      case (r_state)
        IDLE:
          if (r_ie && |w_active) begin
            r_state   <= REQ;
            r_cpu_int <= 1'b1;
            r_cause   <= w_sel;
          end
        REQ:
          if (bus.int_ack) begin
            r_state   <= SERVICE;
            r_cpu_int <= 1'b0;
          end else if (!r_ie || !(|w_active)) begin
            r_state   <= IDLE;
            r_cpu_int <= 1'b0;
          end else r_cause <= w_sel;
        SERVICE:
          if (bus.eret) r_state <= IDLE;
        default: begin
          r_state   <= IDLE;
          r_cpu_int <= 1'b0;
        end
      endcase
    end
  end
  assign bus.cpu_int    = r_cpu_int;
  assign bus.epc_out    = r_epc;
  assign bus.cause_id   = r_cause;
  assign bus.vector_out = VECTOR_BASE + 32'(r_cause) * VECTOR_STRIDE;
  assign bus.cfg_rdata  = bus.cfg_addr == 2'd0 ? {31'b0, r_ie} :
                          bus.cfg_addr == 2'd1 ? 32'(r_mask) :
                          bus.cfg_addr == 2'd2 ? 32'(w_pend) : r_epc;
endmodule

// File: tb/tb_cp0_int_ctrl.sv
// tb_cp0_int_ctrl: directed self-checking bench for cp0_int_ctrl
module tb_cp0_int_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  cp0_int_ctrl_if #(.NUM_IRQ(8))  a_if ();
  cp0_int_ctrl_if #(.NUM_IRQ(8))  b_if ();
  cp0_int_ctrl_if #(.NUM_IRQ(32)) c_if ();
  cp0_int_ctrl #(.NUM_IRQ(8)) u_a (.clk(clk), .reset(reset), .bus(a_if.slave));
  cp0_int_ctrl #(.NUM_IRQ(8), .EDGE_MASK(32'h0)) u_b (.clk(clk), .reset(reset), .bus(b_if.slave));
  cp0_int_ctrl #(.NUM_IRQ(32), .EDGE_MASK(32'hFFFF_FFFF), .VECTOR_BASE(32'hFFFF_FF80),
                 .VECTOR_STRIDE(32'd8)) u_c (.clk(clk), .reset(reset), .bus(c_if.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a_if.irq_in = '0; a_if.int_ack = 0; a_if.eret = 0; a_if.pc_in = '0;
    a_if.cfg_we = 0; a_if.cfg_addr = '0; a_if.cfg_wdata = '0;
    b_if.irq_in = '0; b_if.int_ack = 0; b_if.eret = 0; b_if.pc_in = '0;
    b_if.cfg_we = 0; b_if.cfg_addr = '0; b_if.cfg_wdata = '0;
    c_if.irq_in = '0; c_if.int_ack = 0; c_if.eret = 0; c_if.pc_in = '0;
    c_if.cfg_we = 0; c_if.cfg_addr = '0; c_if.cfg_wdata = '0;
  endtask

  task automatic test_reset();
    n_chk++; if (a_if.cpu_int !== 1'b0) begin n_fail++; $display("FAIL reset_int: got %b want 0", a_if.cpu_int); end
    n_chk++; if (a_if.epc_out !== 32'h0) begin n_fail++; $display("FAIL reset_epc: got %h want 0", a_if.epc_out); end
    n_chk++; if (a_if.vector_out !== 32'h4) begin n_fail++; $display("FAIL reset_vec: got %h want 4", a_if.vector_out); end
    n_chk++; if (a_if.cause_id !== 5'd0) begin n_fail++; $display("FAIL reset_cause: got %0d want 0", a_if.cause_id); end
    n_chk++; if (c_if.vector_out !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL reset_vec_c: got %h want ffffff80", c_if.vector_out); end
    a_if.cfg_addr = 2'd0; #1;
    n_chk++; if (a_if.cfg_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h want 0", a_if.cfg_rdata); end
    a_if.cfg_addr = 2'd1; #1;
    n_chk++; if (a_if.cfg_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_mask: got %h want 0", a_if.cfg_rdata); end
    a_if.cfg_addr = 2'd2; #1;
    n_chk++; if (a_if.cfg_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_pend: got %h want 0", a_if.cfg_rdata); end
  endtask

  task automatic test_basic();
    a_if.cfg_we = 1; a_if.cfg_addr = 2'd0; a_if.cfg_wdata = 32'h1; step();
    a_if.cfg_addr = 2'd1; a_if.cfg_wdata = 32'hFFFF_FFFF; step();
    a_if.cfg_we = 0; a_if.cfg_addr = 2'd0; #1;
    n_chk++; if (a_if.cfg_rdata !== 32'h1) begin n_fail++; $display("FAIL cfg_status: got %h want 1", a_if.cfg_rdata); end
    a_if.cfg_addr = 2'd1; #1;
    n_chk++; if (a_if.cfg_rdata !== 32'hFF) begin n_fail++; $display("FAIL cfg_mask_trunc: got %h want ff", a_if.cfg_rdata); end
    a_if.irq_in = 8'h08; step();
    a_if.irq_in = 8'h00;
    n_chk++; if (a_if.cpu_int !== 1'b0) begin n_fail++; $display("FAIL basic_latency: got %b want 0", a_if.cpu_int); end
    step();
    n_chk++; if (a_if.cpu_int !== 1'b1) begin n_fail++; $display("FAIL basic_int: got %b want 1", a_if.cpu_int); end
    n_chk++; if (a_if.cause_id !== 5'd3) begin n_fail++; $display("FAIL basic_cause: got %0d want 3", a_if.cause_id); end
    n_chk++; if (a_if.vector_out !== 32'h10) begin n_fail++; $display("FAIL basic_vec: got %h want 10", a_if.vector_out); end
    a_if.pc_in = 32'h40; a_if.int_ack = 1; step();
    a_if.int_ack = 0;
    n_chk++; if (a_if.epc_out !== 32'h40) begin n_fail++; $display("FAIL basic_epc: got %h want 40", a_if.epc_out); end
    n_chk++; if (a_if.cpu_int !== 1'b0) begin n_fail++; $display("FAIL basic_ack_int: got %b want 0", a_if.cpu_int); end
    a_if.cfg_addr = 2'd2; #1;
    n_chk++; if (a_if.cfg_rdata !== 32'h0) begin n_fail++; $display("FAIL basic_pend_clr: got %h want 0", a_if.cfg_rdata); end
    a_if.cfg_addr = 2'd0; #1;
    n_chk++; if (a_if.cfg_rdata !== 32'h0) begin n_fail++; $display("FAIL basic_ie_off: got %h want 0", a_if.cfg_rdata); end
    a_if.eret = 1; step();
    a_if.eret = 0; #1;
    n_chk++; if (a_if.cfg_rdata !== 32'h1) begin n_fail++; $display("FAIL basic_ie_on: got %h want 1", a_if.cfg_rdata); end
    step();
    n_chk++; if (a_if.cpu_int !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got %b want 0", a_if.cpu_int); end
  endtask

  task automatic test_preempt();
    a_if.irq_in = 8'h20; step();
    a_if.irq_in = 8'h00; step();
    n_chk++; if (a_if.cause_id !== 5'd5) begin n_fail++; $display("FAIL pre_cause5: got %0d want 5", a_if.cause_id); end
    a_if.irq_in = 8'h02; step();
    a_if.irq_in = 8'h00; step();
    n_chk++; if (a_if.cause_id !== 5'd1) begin n_fail++; $display("FAIL pre_cause1: got %0d want 1", a_if.cause_id); end
    n_chk++; if (a_if.cpu_int !== 1'b1) begin n_fail++; $display("FAIL pre_int: got %b want 1", a_if.cpu_int); end
    a_if.pc_in = 32'h80; a_if.int_ack = 1; step();
    a_if.int_ack = 0; a_if.cfg_addr = 2'd2; #1;
    n_chk++; if (a_if.vector_out !== 32'h08) begin n_fail++; $display("FAIL pre_vec: got %h want 08", a_if.vector_out); end
    n_chk++; if (a_if.cfg_rdata !== 32'h20) begin n_fail++; $display("FAIL pre_pend5: got %h want 20", a_if.cfg_rdata); end
    a_if.eret = 1; step();
    a_if.eret = 0;
    n_chk++; if (a_if.cpu_int !== 1'b0) begin n_fail++; $display("FAIL b2b_eret_edge: got %b want 0", a_if.cpu_int); end
    step();
    n_chk++; if (a_if.cpu_int !== 1'b1) begin n_fail++; $display("FAIL b2b_int: got %b want 1", a_if.cpu_int); end
    n_chk++; if (a_if.cause_id !== 5'd5) begin n_fail++; $display("FAIL b2b_cause: got %0d want 5", a_if.cause_id); end
    a_if.int_ack = 1; step();
    a_if.int_ack = 0; a_if.eret = 1; step();
    a_if.eret = 0; step();
    n_chk++; if (a_if.cpu_int !== 1'b0) begin n_fail++; $display("FAIL pre_done: got %b want 0", a_if.cpu_int); end
  endtask

  task automatic test_ie();
    a_if.cfg_we = 1; a_if.cfg_addr = 2'd0; a_if.cfg_wdata = 32'h0; step();
    a_if.cfg_we = 0; a_if.irq_in = 8'h01; step();
    a_if.irq_in = 8'h00; step(); step();
    n_chk++; if (a_if.cpu_int !== 1'b0) begin n_fail++; $display("FAIL ie_blocked: got %b want 0", a_if.cpu_int); end
    a_if.cfg_we = 1; a_if.cfg_wdata = 32'h1; step();
    a_if.cfg_we = 0;
    n_chk++; if (a_if.cpu_int !== 1'b0) begin n_fail++; $display("FAIL ie_wr_delay: got %b want 0", a_if.cpu_int); end
    step();
    n_chk++; if (a_if.cpu_int !== 1'b1) begin n_fail++; $display("FAIL ie_int: got %b want 1", a_if.cpu_int); end
    n_chk++; if (a_if.cause_id !== 5'd0) begin n_fail++; $display("FAIL ie_cause: got %0d want 0", a_if.cause_id); end
    a_if.pc_in = 32'hC0; a_if.int_ack = 1; step();
    a_if.int_ack = 0;
    a_if.irq_in = 8'h01; a_if.cfg_we = 1; a_if.cfg_addr = 2'd2; a_if.cfg_wdata = 32'h1; step();
    a_if.irq_in = 8'h00; a_if.cfg_we = 0; #1;
    n_chk++; if (a_if.cfg_rdata !== 32'h1) begin n_fail++; $display("FAIL w1c_set_wins: got %h want 1", a_if.cfg_rdata); end
    a_if.cfg_we = 1; a_if.cfg_wdata = 32'hFF; step();
    a_if.cfg_we = 0; #1;
    n_chk++; if (a_if.cfg_rdata !== 32'h0) begin n_fail++; $display("FAIL w1c_clear: got %h want 0", a_if.cfg_rdata); end
    a_if.eret = 1; step();
    a_if.eret = 0; step();
    n_chk++; if (a_if.cpu_int !== 1'b0) begin n_fail++; $display("FAIL ie_idle: got %b want 0", a_if.cpu_int); end
    a_if.pc_in = 32'h1234; a_if.int_ack = 1; step();
    a_if.int_ack = 0;
    n_chk++; if (a_if.epc_out !== 32'hC0) begin n_fail++; $display("FAIL ack_ignored: got %h want c0", a_if.epc_out); end
    a_if.cfg_we = 1; a_if.cfg_addr = 2'd3; a_if.cfg_wdata = 32'hDEAD_BEEF; step();
    a_if.cfg_we = 0;
    n_chk++; if (a_if.epc_out !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL epc_write: got %h want deadbeef", a_if.epc_out); end
  endtask

  task automatic test_level();
    b_if.cfg_we = 1; b_if.cfg_addr = 2'd0; b_if.cfg_wdata = 32'h1; step();
    b_if.cfg_addr = 2'd1; b_if.cfg_wdata = 32'hFF; step();
    b_if.cfg_we = 0; b_if.irq_in = 8'h04; step(); step();
    n_chk++; if (b_if.cpu_int !== 1'b1) begin n_fail++; $display("FAIL lvl_int: got %b want 1", b_if.cpu_int); end
    n_chk++; if (b_if.cause_id !== 5'd2) begin n_fail++; $display("FAIL lvl_cause: got %0d want 2", b_if.cause_id); end
    b_if.cfg_we = 1; b_if.cfg_addr = 2'd2; b_if.cfg_wdata = 32'h4; step();
    b_if.cfg_we = 0; #1;
    n_chk++; if (b_if.cfg_rdata !== 32'h4) begin n_fail++; $display("FAIL lvl_w1c_ignored: got %h want 4", b_if.cfg_rdata); end
    b_if.pc_in = 32'h200; b_if.int_ack = 1; step();
    b_if.int_ack = 0;
    n_chk++; if (b_if.cpu_int !== 1'b0) begin n_fail++; $display("FAIL lvl_ack: got %b want 0", b_if.cpu_int); end
    n_chk++; if (b_if.epc_out !== 32'h200) begin n_fail++; $display("FAIL lvl_epc: got %h want 200", b_if.epc_out); end
    b_if.eret = 1; step();
    b_if.eret = 0; step();
    n_chk++; if (b_if.cpu_int !== 1'b1) begin n_fail++; $display("FAIL lvl_rereq: got %b want 1", b_if.cpu_int); end
    b_if.irq_in = 8'h00; step();
    n_chk++; if (b_if.cpu_int !== 1'b1) begin n_fail++; $display("FAIL lvl_drop_q: got %b want 1", b_if.cpu_int); end
    step();
    n_chk++; if (b_if.cpu_int !== 1'b0) begin n_fail++; $display("FAIL lvl_drop: got %b want 0", b_if.cpu_int); end
  endtask

  task automatic test_reset_service();
    a_if.irq_in = 8'h10; step();
    a_if.irq_in = 8'h00; step();
    n_chk++; if (a_if.cause_id !== 5'd4) begin n_fail++; $display("FAIL rs_cause: got %0d want 4", a_if.cause_id); end
    a_if.pc_in = 32'h100; a_if.int_ack = 1; step();
    a_if.int_ack = 0;
    n_chk++; if (a_if.epc_out !== 32'h100) begin n_fail++; $display("FAIL rs_epc: got %h want 100", a_if.epc_out); end
    reset = 1; a_if.eret = 1; step();
    reset = 0; a_if.eret = 0; a_if.cfg_addr = 2'd0; #1;
    n_chk++; if (a_if.epc_out !== 32'h0) begin n_fail++; $display("FAIL rs_epc0: got %h want 0", a_if.epc_out); end
    n_chk++; if (a_if.vector_out !== 32'h4) begin n_fail++; $display("FAIL rs_vec: got %h want 4", a_if.vector_out); end
    n_chk++; if (a_if.cause_id !== 5'd0) begin n_fail++; $display("FAIL rs_cause0: got %0d want 0", a_if.cause_id); end
    n_chk++; if (a_if.cfg_rdata !== 32'h0) begin n_fail++; $display("FAIL rs_ie: got %h want 0", a_if.cfg_rdata); end
    a_if.cfg_addr = 2'd1; #1;
    n_chk++; if (a_if.cfg_rdata !== 32'h0) begin n_fail++; $display("FAIL rs_mask: got %h want 0", a_if.cfg_rdata); end
    step();
    n_chk++; if (a_if.cpu_int !== 1'b0) begin n_fail++; $display("FAIL rs_int: got %b want 0", a_if.cpu_int); end
  endtask

  task automatic test_wrap();
    c_if.cfg_we = 1; c_if.cfg_addr = 2'd0; c_if.cfg_wdata = 32'h1; step();
    c_if.cfg_addr = 2'd1; c_if.cfg_wdata = 32'hFFFF_FFFF; step();
    c_if.cfg_we = 0; #1;
    n_chk++; if (c_if.cfg_rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_mask: got %h want ffffffff", c_if.cfg_rdata); end
    c_if.irq_in = 32'h8000_0000; step();
    c_if.irq_in = '0; step();
    n_chk++; if (c_if.cpu_int !== 1'b1) begin n_fail++; $display("FAIL wrap_int: got %b want 1", c_if.cpu_int); end
    n_chk++; if (c_if.cause_id !== 5'd31) begin n_fail++; $display("FAIL wrap_cause: got %0d want 31", c_if.cause_id); end
    n_chk++; if (c_if.vector_out !== 32'h0000_0078) begin n_fail++; $display("FAIL wrap_vec: got %h want 00000078", c_if.vector_out); end
  endtask

  initial begin
    clear_inputs();
    step(); step();
    reset = 0;
    test_reset();
    test_basic();
    test_preempt();
    test_ie();
    test_level();
    test_reset_service();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
